// File: rtl/div_unit_pkg.sv
// Shared constants for the E-stage radix-2 restoring divider.
// State encodings and the divide-by-zero quotient value.
package div_unit_pkg;

  localparam logic [1:0] DIV_IDLE = 2'b00;
  localparam logic [1:0] DIV_BUSY = 2'b01;
  localparam logic [1:0] DIV_DONE = 2'b10;

  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: one restoring step per cycle, {HI=rem, LO=quo}.
// Optional DIV_ZERO_FAST_EN: divide-by-zero skips the iterations.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               annul_i,
  output logic               stall_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_b;
  logic               r_qneg;
  logic               r_rneg;
  logic               r_zero;
  logic [2*WIDTH-1:0] r_result;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_b_zero;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nx;
  logic [WIDTH-1:0]   w_quo_nx;
  logic               w_last;
  logic [WIDTH-1:0]   w_q_fin;
  logic [WIDTH-1:0]   w_r_fin;

  function automatic logic [WIDTH-1:0] div_sign_fix(
    input logic [WIDTH-1:0] v,
    input logic             neg
  );
    return neg ? -v : v;
  endfunction

  assign w_a_neg  = signed_i & a_i[WIDTH-1];
  assign w_b_neg  = signed_i & b_i[WIDTH-1];
  assign w_a_mag  = div_sign_fix(a_i, w_a_neg);
  assign w_b_mag  = div_sign_fix(b_i, w_b_neg);
  assign w_b_zero = (b_i == '0);

  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_b};
  assign w_ge     = ~w_diff[WIDTH];
  assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0]
                         : w_shift[WIDTH-1:0];
  assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};
  assign w_last   = (r_count == CW'(WIDTH - 1));

  // With b==0 the remainder accumulates |a|; its sign fix restores raw a.
  assign w_q_fin = r_zero ? WIDTH'(DIV_ZERO_QUOT)
                          : div_sign_fix(w_quo_nx, r_qneg);
  assign w_r_fin = div_sign_fix(w_rem_nx, r_rneg);

  assign stall_o = ~annul_i &
                   (((r_state == DIV_IDLE) & start_i) |
                    (r_state == DIV_BUSY));
  assign ready_o  = (r_state == DIV_DONE);
  assign result_o = r_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= DIV_IDLE;
      r_count  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_b      <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_zero   <= 1'b0;
      r_result <= '0;
    end else if (annul_i) begin
      r_state <= DIV_IDLE;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (start_i) begin
            r_count <= '0;
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_b     <= w_b_mag;
            r_qneg  <= w_a_neg ^ w_b_neg;
            r_rneg  <= w_a_neg;
            r_zero  <= w_b_zero;
`ifdef DIV_ZERO_FAST_EN
            if (w_b_zero) begin
              r_result <= {a_i, WIDTH'(DIV_ZERO_QUOT)};
              r_state  <= DIV_DONE;
            end else begin
              r_state  <= DIV_BUSY;
            end
`else
            r_state <= DIV_BUSY;
`endif
          end
        end
        DIV_BUSY: begin
          r_rem   <= w_rem_nx;
          r_quo   <= w_quo_nx;
          r_count <= r_count + CW'(1);
          if (w_last) begin
            r_result <= {w_r_fin, w_q_fin};
            r_state  <= DIV_DONE;
          end
        end
        // start_i may still be high here; it belongs to the finished op.
        DIV_DONE: r_state <= DIV_IDLE;
        default:  r_state <= DIV_IDLE;
      endcase
    end
  end

endmodule
